// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the shared-memory MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback. The run/step
// inputs let debug logic free-run the CPU or single-step one instruction.
//
// Ports
//   clk, rst         rising-edge clock, async active-high reset
//   op, funct        IR[31:26], IR[5:0]
//   zero             ALU zero flag (consumed by the datapath PC-write logic)
//   run, step        run level / single-step pulse
//   pc_write .. pc_source  datapath mux selects and write enables
//   instr_done       pulse in the last state of every instruction
//   halted           high while in WAIT
//   err              sticky illegal-opcode flag (held until rst)
//
// Moore machine: every output decodes from state_q only.
module mc_ctrl #(
  parameter bit RESET_RUN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       run,
  input  logic       step,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       halted,
  output logic       err
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // IEXEC/IWB are split into plain and _OR flavours so that the ori
  // alu_op / zero-extend selection is carried by the state, not by op.
  typedef enum logic [3:0] {
    S_WAIT, S_FETCH, S_DECODE, S_REXEC, S_RWB, S_MADDR, S_MREAD, S_MWB,
    S_MWRITE, S_BR, S_JMP, S_IEXEC, S_IEXEC_OR, S_IWB, S_IWB_OR, S_ERR
  } state_t;

  state_t state_q, state_d;
  logic   run_q, run_d;

  // funct is decoded by the ALU control block; zero feeds the PC-write gate.
  logic unused_ok;
  assign unused_ok = ^{funct, zero};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT;
      run_q   <= RESET_RUN;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign run_d = run;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:     if (run || step) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_RTYPE:      state_d = S_REXEC;
          OP_LW, OP_SW:  state_d = S_MADDR;
          OP_BEQ:        state_d = S_BR;
          OP_J:          state_d = S_JMP;
          OP_ADDI:       state_d = S_IEXEC;
          OP_ORI:        state_d = S_IEXEC_OR;
          default:       state_d = S_ERR;
        endcase
      end
      S_REXEC:    state_d = S_RWB;
      S_MADDR:    state_d = (op == OP_LW) ? S_MREAD : S_MWRITE;
      S_MREAD:    state_d = S_MWB;
      S_IEXEC:    state_d = S_IWB;
      S_IEXEC_OR: state_d = S_IWB_OR;
      S_RWB, S_MWB, S_MWRITE, S_BR, S_JMP, S_IWB, S_IWB_OR:
                  state_d = run_q ? S_FETCH : S_WAIT;
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_WAIT;
    endcase
  end

  // Output decode from state only
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    ext_op        = 1'b1;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    halted        = 1'b0;
    err           = 1'b0;
    unique case (state_q)
      // WAIT is the reset state, where every control output is low.
      S_WAIT: begin
        halted = 1'b1;
        ext_op = 1'b0;
      end
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MREAD:    i_or_d = 1'b1;
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MWRITE: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_IEXEC_OR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        ext_op    = 1'b0;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      // Immediate still on the ALU path; keep it zero-extended.
      S_IWB_OR: begin
        reg_write  = 1'b1;
        ext_op     = 1'b0;
        instr_done = 1'b1;
      end
      S_ERR:      err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS datapath. It sequences a shared-memory datapath (one ALU, one memory port) through fetch, decode, execute, memory and writeback.
- A run/step interface lets the bench or debug logic free-run the CPU or single-step it one instruction at a time.
- Sits between the IR opcode/funct fields and every datapath mux and write-enable in the multicycle computer top.

Parameters:
- RESET_RUN, 1, value `run_q` takes on reset (1 = start free-running after reset deasserts).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- run  in  1  level; 1 = free-run, 0 = stop at next instruction boundary
- step  in  1  one-cycle pulse; execute exactly one instruction while stopped
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- i_or_d  out  1  memory address mux: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  IR load
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decode, 11 or
- ext_op  out  1  1 = sign extend, 0 = zero extend
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- halted  out  1  1 while in WAIT
- err  out  1  sticky illegal-opcode flag

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register only; no output depends on `op`, `funct` or `zero` in the same cycle.
- Outputs not listed for a state are 0, except `ext_op`, which defaults to 1.
- Reset: state = WAIT; all control outputs 0; `halted` = 1; `err` = 0. Reset mid-instruction abandons the instruction and writes nothing in that cycle or after.
- WAIT: `halted` = 1. Go to FETCH if `run` or `step`, else stay.
- FETCH: `ir_write`, `pc_write`, `alu_src_b` = 01, `pc_source` = 00 (PC += 4). Go to DECODE.
- DECODE: `alu_src_b` = 11 (branch target into ALUOut). Dispatch on `op`:
  - 000000 -> REXEC
  - 100011 / 101011 -> MADDR
  - 000100 -> BR
  - 000010 -> JMP
  - 001000 -> IEXEC
  - 001101 -> IEXEC
  - any other -> ERR
- REXEC: `alu_src_a` = 1, `alu_op` = 10. Go to RWB.
- RWB: `reg_write`, `reg_dst` = 1. Last state.
- MADDR: `alu_src_a` = 1, `alu_src_b` = 10. Go to MREAD if `op` = 100011, else MWRITE.
- MREAD: `i_or_d` = 1. Go to MWB.
- MWB: `reg_write`, `mem_to_reg` = 1. Last state.
- MWRITE: `i_or_d` = 1, `mem_write`. Last state.
- BR: `alu_src_a` = 1, `alu_op` = 01, `pc_write_cond`, `pc_source` = 01. Last state.
- JMP: `pc_write`, `pc_source` = 10. Last state.
- IEXEC: `alu_src_a` = 1, `alu_src_b` = 10. If `op` = 001101: `alu_op` = 11 and `ext_op` = 0; otherwise `alu_op` = 00. This requires an opcode-latched substate, IEXEC_OR, so the outputs stay a function of state only. Go to IWB.
- IWB: `reg_write`, `reg_dst` = 0; `ext_op` holds the IEXEC value. Last state.
- Last-state rule: `instr_done` = 1. Next state is FETCH if `run_q`, else WAIT.
- ERR: all write enables 0, `err` = 1. Stays in ERR until `rst`; `run` and `step` are ignored.
- Instruction latencies:
  - R-type = 4 cycles
  - lw = 5
  - sw = 4
  - beq = 3
  - j = 3
  - addi/ori = 4
- Run/step handling:
  - `run_q` is a register that samples `run` every cycle.
  - A `step` pulse seen while in WAIT launches exactly one instruction.
  - `step` is ignored outside WAIT.
  - If `run` and `step` are both high in WAIT, the result is free-running.
  - Deasserting `run` mid-instruction completes the current instruction, then the FSM enters WAIT.

Test Plan:
- `rst` high 20 ns, `run` = 1, IR = add (op 0, funct 0x20) -> state sequence WAIT, FETCH, DECODE, REXEC, RWB; `reg_write` = 1 and `reg_dst` = 1 in cycle 4; `instr_done` pulse in cycle 4; next state FETCH.
- lw (op 0x23) then sw (op 0x2B) -> lw shows `mem_to_reg` = 1 with `reg_write` in cycle 5; sw shows `mem_write` = 1 with `i_or_d` = 1 in cycle 4, with `reg_write` = 0 throughout.
- beq (op 0x04), `zero` = 1 and then `zero` = 0 -> BR state asserts `pc_write_cond` = 1 and `pc_source` = 01 in both cases; 3-cycle latency; ori (0x0D) asserts `ext_op` = 0 and `alu_op` = 11 in execute.
- `run` = 0 after reset, then a single `step` pulse with IR = j (0x02) -> `halted` = 1 until the step; exactly one FETCH-DECODE-JMP sequence; back in WAIT with `halted` = 1; a second `step` during DECODE is ignored.
- Illegal op 0x3F -> ERR after DECODE; `err` = 1 and all write enables 0 for 50 cycles despite `run` = 1; asserting `rst` returns the FSM to WAIT with `err` = 0.
- Assert `rst` during MREAD of a lw -> outputs go to 0 immediately (asynchronously); no `reg_write` pulse afterwards; the FSM restarts from WAIT.
